uart_tx_arbiter: RTL and testbench

//  Shares the UART transmit path (TX FIFO write port: wr_uart/w_data/tx_full) among

---
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART TX FIFO write port among NREQ byte-stream requesters.
//   Round-robin arbitration at packet granularity: the owner keeps the port
//   until it sends a byte flagged last or until MAX_BURST bytes have gone.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-low reset
//   req_valid  per-requester byte valid
//   req_last   per-requester: current byte ends its packet
//   req_data   requester i byte on [i*DBIT +: DBIT]
//   req_ready  per-requester accept (byte moves when valid & ready)
//   tx_full    UART TX FIFO full
//   wr_uart    TX FIFO write strobe
//   w_data     TX FIFO write data
//   grant      one-hot current owner, 0 when idle
//   busy       high while a requester owns the port
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int DBIT          = 8,
  parameter int MAX_BURST     = 16,
  parameter int MAX_BURST_BIT = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic [NREQ-1:0]      grant,
  output logic                 busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  logic [0:0]               r_state;
  logic [NREQ-1:0]          r_grant;
  logic [PTR_W-1:0]         r_owner;
  logic [PTR_W-1:0]         r_ptr;
  logic [MAX_BURST_BIT-1:0] r_cnt;

  logic                     w_found;
  logic [PTR_W-1:0]         w_pick;
  logic                     w_busy;
  logic                     w_xfer;
  logic                     w_release;

  // Round-robin search: first valid requester starting just after the last
  // owner, wrapping around.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = PTR_W'(idx);
      end
    end
  end

  assign w_busy    = (r_state == S_XFER);
  assign w_xfer    = w_busy & req_valid[r_owner] & ~tx_full;
  // Release on end of packet, or when this byte completes the burst cap.
  assign w_release = req_last[r_owner] |
                     (r_cnt == MAX_BURST_BIT'(MAX_BURST - 1));

  // Ready only to the owner and only when the FIFO can take the byte; grant
  // is all-zero in IDLE so no ready bit leaks out there.
  assign req_ready = r_grant & {NREQ{~tx_full}};
  assign wr_uart   = w_xfer;
  assign w_data    = req_data[int'(r_owner)*DBIT +: DBIT];
  assign grant     = r_grant;
  assign busy      = w_busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= PTR_W'(NREQ - 1);  // requester 0 wins the first arbitration
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= NREQ'(1) << w_pick;
            r_owner <= w_pick;
            r_cnt   <= '0;
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          // tx_full or an idle owner simply stalls here: nothing changes.
          if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_release) begin
              r_ptr   <= r_owner;
              r_grant <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. Each requester has a byte queue
//   presented on its valid/last/data lines; expected FIFO writes are pushed to
//   a scoreboard in the order the arbitration rules dictate and compared when
//   wr_uart fires.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NREQ          = 4;
  localparam int DBIT          = 8;
  localparam int MAX_BURST     = 16;
  localparam int MAX_BURST_BIT = 5;

  typedef struct {
    int         req;
    logic [7:0] data;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;
  logic [NREQ-1:0]      grant;
  logic                 busy;

  logic [8:0] strm [NREQ][$];   // {last, data} per requester
  exp_t       sb   [$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int cyc     = 0;
  int prev_wr = -1;
  bit gap_chk = 0;

  uart_tx_arbiter #(
    .NREQ(NREQ), .DBIT(DBIT), .MAX_BURST(MAX_BURST), .MAX_BURST_BIT(MAX_BURST_BIT)
  ) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_bytes(input int r, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) strm[r].push_back({(j == n - 1), 8'(base + j)});
  endtask

  task automatic expect_bytes(input int r, input logic [7:0] base, input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.req  = r;
      e.data = 8'(base + j);
      sb.push_back(e);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) strm[i].delete();
    sb.delete();
  endtask

  // Test-side sampling point: well clear of both clock edges.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_writes(input int target, input int budget);
    int k = 0;
    while (n_wr < target && k < budget) begin
      tick();
      k++;
    end
    check("wait_writes_timeout", 32'(n_wr >= target), 1);
  endtask

  task automatic wait_done(input int budget);
    int  k = 0;
    bit  pending = 1;
    while (pending && k < budget) begin
      tick();
      k++;
      pending = busy;
      for (int i = 0; i < NREQ; i++) if (strm[i].size() != 0) pending = 1;
      if (sb.size() != 0) pending = 1;
    end
    check("wait_done_timeout", 32'(pending), 0);
  endtask

  task automatic apply_reset();
    tick();
    rst_n = 1'b0;
    clear_all();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Driver + monitor: handshake and writes are sampled at the falling edge,
  // requester queues advance and are re-presented just after the rising edge.
  initial begin
    logic [NREQ-1:0] acc;
    exp_t            e;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      acc = '0;
      if (rst_n) begin
        acc = req_valid & req_ready;
        if (wr_uart || (acc != '0)) begin
          check("wr_vs_handshake", 32'(wr_uart), 32'(acc != '0));
          check("wr_while_full", 32'(wr_uart & tx_full), 0);
        end
        if (wr_uart) begin
          n_wr++;
          if (gap_chk && prev_wr >= 0) check("wr_gap", 32'(cyc - prev_wr), 2);
          prev_wr = cyc;
          if (sb.size() == 0) begin
            check("spurious_write", 32'(w_data), 32'hFFFF);
          end else begin
            e = sb.pop_front();
            check("wr_data", 32'(w_data), 32'(e.data));
            check("wr_grant", 32'(grant), 32'(1 << e.req));
            check("wr_ready", 32'(acc), 32'(1 << e.req));
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && strm[i].size() != 0) void'(strm[i].pop_front());
        if (strm[i].size() != 0) begin
          req_valid[i]           = 1'b1;
          req_last[i]            = strm[i][0][8];
          req_data[i*DBIT +: DBIT] = strm[i][0][7:0];
        end else begin
          req_valid[i]           = 1'b0;
          req_last[i]            = 1'b0;
          req_data[i*DBIT +: DBIT] = '0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n   = 1'b0;
    tx_full = 1'b0;

    // 1: reset values
    repeat (2) tick();
    check("rst_wr_uart", 32'(wr_uart), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    tick();

    // 2: req0 three-byte packet, one cycle arbitration latency
    push_bytes(0, 8'hA1, 3);
    expect_bytes(0, 8'hA1, 3);
    tick();
    check("t2_valid_seen", 32'(req_valid[0]), 1);
    check("t2_arb_grant", 32'(grant), 0);
    check("t2_arb_wr", 32'(wr_uart), 0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("t2_grant", 32'(grant), 32'h1);
      check("t2_wr", 32'(wr_uart), 1);
    end
    tick();
    check("t2_end_wr", 32'(wr_uart), 0);
    check("t2_end_grant", 32'(grant), 0);
    check("t2_end_busy", 32'(busy), 0);
    wait_done(20);

    // 3: all four valid with one-byte packets, fresh pointer -> 0,1,2,3,0
    apply_reset();
    gap_chk = 1;
    prev_wr = -1;
    push_bytes(0, 8'h30, 1);
    push_bytes(0, 8'h40, 1);
    push_bytes(1, 8'h31, 1);
    push_bytes(2, 8'h32, 1);
    push_bytes(3, 8'h33, 1);
    expect_bytes(0, 8'h30, 1);
    expect_bytes(1, 8'h31, 1);
    expect_bytes(2, 8'h32, 1);
    expect_bytes(3, 8'h33, 1);
    expect_bytes(0, 8'h40, 1);
    wait_done(50);
    gap_chk = 0;

    // 4: req1 20-byte packet with req2 waiting -> 16, req2 packet, 4
    push_bytes(1, 8'h00, 20);
    push_bytes(2, 8'hC0, 3);
    expect_bytes(1, 8'h00, 16);
    expect_bytes(2, 8'hC0, 3);
    expect_bytes(1, 8'h10, 4);
    wait_done(100);

    // 5: FIFO full for 5 cycles mid-packet
    base = n_wr;
    push_bytes(0, 8'h50, 8);
    expect_bytes(0, 8'h50, 8);
    wait_writes(base + 3, 30);
    tx_full = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("t5_full_wr", 32'(wr_uart), 0);
      check("t5_full_ready", 32'(req_ready), 0);
      check("t5_full_grant", 32'(grant), 32'h1);
    end
    tx_full = 1'b0;
    wait_done(50);
    check("t5_write_count", 32'(n_wr - base), 8);

    // 6: reset mid-transfer, then requester 0 must win first
    base = n_wr;
    push_bytes(0, 8'h60, 6);
    expect_bytes(0, 8'h60, 6);
    wait_writes(base + 2, 30);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr", 32'(wr_uart), 0);
    check("t6_rst_grant", 32'(grant), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_ready", 32'(req_ready), 0);
    clear_all();
    repeat (2) tick();
    rst_n = 1'b1;
    push_bytes(0, 8'h70, 1);
    push_bytes(1, 8'h71, 1);
    expect_bytes(0, 8'h70, 1);
    expect_bytes(1, 8'h71, 1);
    wait_done(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
